// File: rtl/mux_pkg.sv
// Shared constants for the registered N-to-1 multiplexer.
`timescale 1ns/1ps

package mux_pkg;

  // Values of the Mode input.
  localparam logic MUX_MODE_SELECT = 1'b0;
  localparam logic MUX_MODE_SCAN   = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority search: returns the first set request at or above ptr_i,
// wrapping from N-1 back to 0. Purely combinational.
`timescale 1ns/1ps

module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;

  // Doubling the vector turns the wrap-around into a plain right shift.
  assign req_dbl = {req_i, req_i};
  assign req_rot = N'(req_dbl >> ptr_i);

  // Lowest set bit of the rotated vector, mapped back to a channel index.
  always_comb begin
    int unsigned pos;
    found_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found_o && req_rot[k]) begin
        found_o = 1'b1;
        pos     = 32'(ptr_i) + k;
        if (pos >= N) pos = pos - N;
        idx_o   = W'(pos);
      end
    end
  end

endmodule

// File: rtl/mux_nto1_reg.sv
// Registered N-to-1 multiplexer with valid/ready output stage, dual-rail
// select checking and round-robin scan mode.
// Build option: define MUX_SEL_CHECK_EN to check Select against _Select and
// drive SelError; otherwise _Select is ignored and SelError stays 0.
`timescale 1ns/1ps

module mux_nto1_reg
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH    = 1,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [CHANNELS*WIDTH-1:0] In,
  input  logic [CHANNELS-1:0]       InValid,
  output logic [CHANNELS-1:0]       InReady,
  input  logic [SEL_W-1:0]          Select,
  input  logic [SEL_W-1:0]          _Select,
  input  logic                      Mode,
  output logic [WIDTH-1:0]          Out,
  output logic [SEL_W-1:0]          OutChannel,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic                      SelError
);

  localparam int unsigned PadW = 1 << SEL_W;

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;

  logic             sel_in_range;
  logic             sel_ok;
  logic [PadW-1:0]  valid_pad;
  logic             scan_found;
  logic [SEL_W-1:0] scan_idx;
  logic             cand_found;
  logic [SEL_W-1:0] chosen;
  logic [WIDTH-1:0] chosen_data;
  logic             load;

  assign sel_in_range = (32'(Select) < CHANNELS);

`ifdef MUX_SEL_CHECK_EN
  assign sel_ok = sel_in_range && (Select == ~_Select);
`else
  assign sel_ok = sel_in_range;
  logic unused_sel_n;
  assign unused_sel_n = ^_Select;
`endif

  // Padded so an out-of-range Select never indexes past the valid vector.
  assign valid_pad = PadW'(InValid);

  rr_pick #(
    .N (CHANNELS),
    .W (SEL_W)
  ) u_rr_pick (
    .req_i   (InValid),
    .ptr_i   (ptr_q),
    .found_o (scan_found),
    .idx_o   (scan_idx)
  );

  // Candidate channel for this cycle, from the scan search or external select.
  always_comb begin
    if (Mode == MUX_MODE_SCAN) begin
      cand_found = scan_found;
      chosen     = scan_idx;
    end else begin
      cand_found = sel_ok && valid_pad[Select];
      chosen     = Select;
    end
  end

  assign load        = cand_found && (!out_valid_q || OutReady);
  assign chosen_data = In[32'(chosen)*WIDTH +: WIDTH];

  // One-hot grant to the channel being loaded; silent while in reset.
  always_comb begin
    InReady = '0;
    if (load && !Reset) InReady = CHANNELS'(1) << chosen;
  end

  // Output register, scan pointer and select-fault next state.
  always_comb begin
    ptr_d       = ptr_q;
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_d       = chosen_data;
      out_ch_d    = chosen;
      out_valid_d = 1'b1;
      if (Mode == MUX_MODE_SCAN) begin
        ptr_d = (32'(chosen) == CHANNELS - 1) ? '0 : chosen + SEL_W'(1);
      end
    end else if (OutReady) begin
      out_valid_d = 1'b0;
    end
`ifdef MUX_SEL_CHECK_EN
    sel_err_d = (Mode == MUX_MODE_SELECT) && !sel_ok;
`else
    sel_err_d = 1'b0;
`endif
  end

  // State registers, cleared asynchronously by Reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ptr_q       <= '0;
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign Out        = out_q;
  assign OutChannel = out_ch_q;
  assign OutValid   = out_valid_q;
  assign SelError   = sel_err_q;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// Scoreboard bench for mux_nto1_reg: stimulus pushes expected {channel, data}
// transfers; a negedge monitor pops one per output handshake.
`timescale 1ns/1ps

module tb_mux_nto1_reg;

`ifdef MUX_SEL_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  // 4-channel, 8-bit instance
  logic [31:0] in_bus;
  logic [3:0]  in_valid, in_ready;
  logic [1:0]  sel, sel_n, out_ch;
  logic        mode, out_valid, out_ready, sel_err;
  logic [7:0]  out_data;
  // 5-channel, 8-bit instance
  logic [39:0] in5;
  logic [4:0]  in_valid5, in_ready5;
  logic [2:0]  sel5, sel5_n, out_ch5;
  logic        mode5, out_valid5, out_ready5, sel_err5;
  logic [7:0]  out5;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  mux_nto1_reg #(.WIDTH(8), .CHANNELS(4)) u_dut (
    .Clock(clk), .Reset(rst), .In(in_bus), .InValid(in_valid), .InReady(in_ready),
    .Select(sel), ._Select(sel_n), .Mode(mode), .Out(out_data), .OutChannel(out_ch),
    .OutValid(out_valid), .OutReady(out_ready), .SelError(sel_err)
  );

  mux_nto1_reg #(.WIDTH(8), .CHANNELS(5)) u_dut5 (
    .Clock(clk), .Reset(rst), .In(in5), .InValid(in_valid5), .InReady(in_ready5),
    .Select(sel5), ._Select(sel5_n), .Mode(mode5), .Out(out5), .OutChannel(out_ch5),
    .OutValid(out_valid5), .OutReady(out_ready5), .SelError(sel_err5)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Channel c carries base + c.
  task automatic set_data(input logic [7:0] base);
    for (int c = 0; c < 4; c++) in_bus[c*8 +: 8] = base + 8'(c);
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] base);
    exp_q.push_back({ch, base + 8'(ch)});
  endtask

  // Monitor: every handshake on the output must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL xfer_unexpected: got ch=%0d data=%0h required none", out_ch, out_data);
      end else begin
        chk("xfer", {22'b0, out_ch, out_data}, {22'b0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  localparam int ScanSeq[6] = '{0, 1, 3, 0, 1, 3};

  initial begin
    rst = 1'b1; in_bus = '0; in_valid = 4'hF; sel = 2'd0; sel_n = 2'd3; mode = 1'b0;
    out_ready = 1'b1;
    in5 = {8'hE4, 8'hE3, 8'hE2, 8'hE1, 8'hE0}; in_valid5 = '0; sel5 = 3'd0; sel5_n = 3'd7;
    mode5 = 1'b0; out_ready5 = 1'b1;
    #3;
    // Reset state; a valid select is presented but no grant may appear
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out_data, 0);
    chk("rst_sel_err", sel_err, 0);
    in_valid = '0;
    cyc();
    rst = 1'b0;
    cyc();

    // Basic external-select load
    set_data(8'hA3); sel = 2'd2; sel_n = 2'd1; in_valid = 4'b0100;
    #1 chk("ext_in_ready", in_ready, 4'b0100);
    push(2'd2, 8'hA3);
    cyc();
    chk("ext_out", out_data, 8'hA5);
    chk("ext_out_ch", out_ch, 2);
    chk("ext_out_valid", out_valid, 1);
    chk("ext_sel_err", sel_err, 0);
    in_valid = '0;
    cyc();
    chk("drain_valid", out_valid, 0);

    // Reset mid-stream clears everything immediately
    set_data(8'h3B); sel = 2'd1; sel_n = 2'd2; in_valid = 4'b0010;
    #1 push(2'd1, 8'h3B);
    cyc();
    chk("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_out", out_data, 0);
    chk("midrst_ch", out_ch, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    in_valid = '0;
    cyc();
    rst = 1'b0;
    cyc();

    // Dual-rail fault: Select=1/_Select=1
    set_data(8'h50); sel = 2'd0; sel_n = 2'd3; in_valid = 4'b1111;
    #1 chk("pre_fault_ready", in_ready, 4'b0001);
    push(2'd0, 8'h50);
    cyc();
    sel = 2'd1; sel_n = 2'd1;
    #1 chk("fault_in_ready", in_ready, CheckEn ? 4'b0000 : 4'b0010);
    if (!CheckEn) push(2'd1, 8'h50);
    cyc();
    chk("fault_out_valid", out_valid, CheckEn ? 0 : 1);
    chk("fault_sel_err", sel_err, CheckEn ? 1 : 0);
    in_valid = '0; sel = 2'd0; sel_n = 2'd3;
    cyc();
    chk("fault_clear_sel_err", sel_err, 0);
    chk("fault_clear_valid", out_valid, 0);

    // Five channels: top channel loads, out-of-range select is refused
    sel5 = 3'd4; sel5_n = 3'd3; in_valid5 = 5'b10000;
    #1 chk("c5_in_ready", in_ready5, 5'b10000);
    cyc();
    chk("c5_out", out5, 8'hE4);
    chk("c5_out_ch", out_ch5, 4);
    sel5 = 3'd6; sel5_n = 3'd1; in_valid5 = 5'b11111;
    #1 chk("c5_oor_in_ready", in_ready5, 0);
    cyc();
    chk("c5_oor_valid", out_valid5, 0);
    chk("c5_oor_sel_err", sel_err5, CheckEn ? 1 : 0);
    in_valid5 = '0; sel5 = 3'd0; sel5_n = 3'd7;

    // Backpressure: held output, no grant, then pass-through on release
    set_data(8'h70); sel = 2'd3; sel_n = 2'd0; in_valid = 4'b1000;
    #1 chk("bp_first_ready", in_ready, 4'b1000);
    push(2'd3, 8'h70);
    cyc();
    out_ready = 1'b0; set_data(8'h80); sel = 2'd0; sel_n = 2'd3; in_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", in_ready, 0);
      cyc();
      chk("bp_hold_out", out_data, 8'h73);
      chk("bp_hold_ch", out_ch, 3);
      chk("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 4'b0001);
    push(2'd0, 8'h80);
    cyc();
    chk("bp_new_out", out_data, 8'h80);
    in_valid = '0;
    cyc();

    // Scan fairness; the faulty select is ignored in scan mode
    mode = 1'b1; sel = 2'd1; sel_n = 2'd1; set_data(8'h90); in_valid = 4'b1011;
    for (int i = 0; i < 6; i++) begin
      #1 chk("scan_in_ready", in_ready, 32'(1) << ScanSeq[i]);
      push(2'(ScanSeq[i]), 8'h90);
      cyc();
      chk("scan_out_ch", out_ch, ScanSeq[i]);
      chk("scan_sel_err", sel_err, 0);
    end
    // Pointer to 3, then wrap to channel 0, then confirm pointer is 1
    in_valid = 4'b0100;
    #1 chk("scan_to3", in_ready, 4'b0100);
    push(2'd2, 8'h90);
    cyc();
    in_valid = 4'b0001;
    #1 chk("scan_wrap", in_ready, 4'b0001);
    push(2'd0, 8'h90);
    cyc();
    in_valid = 4'b0011;
    #1 chk("scan_ptr1", in_ready, 4'b0010);
    push(2'd1, 8'h90);
    cyc();
    // Back to external select
    mode = 1'b0; sel = 2'd3; sel_n = 2'd0; in_valid = 4'b1000;
    #1 chk("switch_ready", in_ready, 4'b1000);
    push(2'd3, 8'h90);
    cyc();
    chk("switch_sel_err", sel_err, 0);
    chk("switch_out_ch", out_ch, 3);
    in_valid = '0;
    cyc();

    // Select=2/_Select=2: accepted only without dual-rail checking
    set_data(8'hB0); sel = 2'd2; sel_n = 2'd2; in_valid = 4'b0100;
    #1 chk("cfg_in_ready", in_ready, CheckEn ? 4'b0000 : 4'b0100);
    if (!CheckEn) push(2'd2, 8'hB0);
    cyc();
    chk("cfg_sel_err", sel_err, CheckEn ? 1 : 0);
    chk("cfg_out_valid", out_valid, CheckEn ? 0 : 1);
    in_valid = '0; sel = 2'd0; sel_n = 2'd3;
    cyc();
    cyc();

    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
